// File: rtl/jtframe_pocket_pkg.sv
// Shared definitions for the Pocket download path: FSM encoding, byte lane
// selection and the ioctl_index values that downstream consumers decode.
package jtframe_pocket_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] IDX_NVRAM = 8'hFF;
  localparam logic [7:0] IDX_CHEAT = 8'h10;

  // Big-endian lane order sends wr_data[31:24] first, matching the APF bridge.
  function automatic logic [7:0] byte_sel(input logic [31:0] word,
                                          input logic [1:0]  cnt,
                                          input logic        bigend);
    logic [1:0] lane;
    lane = bigend ? ~cnt : cnt;
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/jtframe_pocket_dwnld_fifo.sv
// Small synchronous FIFO with a combinational head; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module jtframe_pocket_dwnld_fifo #(
  parameter int DATA_W = 55,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/jtframe_pocket_dwnld.sv
// Turns buffered 32-bit APF bridge writes into paced ioctl byte writes and
// tracks the download/overflow status seen by the rest of the core.
module jtframe_pocket_dwnld
  import jtframe_pocket_pkg::*;
#(
  parameter int AW     = 25,
  parameter int FIFOAW = 2,
  parameter bit BIGEND = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slot_start,
  input  logic [7:0]      slot_id,
  input  logic            slot_done,
  input  logic            wr,
  input  logic [31:0]     wr_addr,
  input  logic [31:0]     wr_data,
  input  logic            prog_rdy,
  output logic [AW-1:0]   ioctl_addr,
  output logic [7:0]      ioctl_dout,
  output logic            ioctl_wr,
  output logic [7:0]      ioctl_index,
  output logic            downloading,
  output logic            overflow,
  output logic [FIFOAW:0] fifo_level
);

  localparam int EW = AW - 2 + 32;

  state_t        state;
  state_t        state_nx;
  logic [EW-1:0] fifo_din;
  logic [EW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          inc_cnt;
  logic          wr_ok;
  logic          done_now;
  logic          pending_done;
  logic [31:0]   shreg;
  logic [AW-3:0] word_addr;
  logic [1:0]    cnt;
  logic          unused_addr;

  assign unused_addr = ^{wr_addr[1:0], wr_addr[31:AW]};
  assign fifo_din    = {wr_addr[AW-1:2], wr_data};
  assign wr_ok       = wr && (!fifo_full || pop);
  // An accepted word in the same cycle keeps the download open.
  assign done_now    = pending_done && (state == ST_IDLE) && fifo_empty && !wr_ok;

  jtframe_pocket_dwnld_fifo #(
    .DATA_W (EW),
    .AW     (FIFOAW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    inc_cnt  = 1'b0;
    ioctl_wr = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) begin
        pop      = 1'b1;
        state_nx = ST_LOAD;
      end
      ST_LOAD: state_nx = ST_EMIT;
      ST_EMIT: begin
        ioctl_wr = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: if (prog_rdy) begin
        if (cnt != 2'd3) begin
          inc_cnt  = 1'b1;
          state_nx = ST_LOAD;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          state_nx = ST_LOAD;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Word holding registers: only meaningful after a pop, so no reset.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg     <= fifo_dout[31:0];
      word_addr <= fifo_dout[EW-1:32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 2'd0;
      ioctl_addr   <= '0;
      ioctl_dout   <= 8'd0;
      ioctl_index  <= 8'd0;
      downloading  <= 1'b0;
      pending_done <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (pop)          cnt <= 2'd0;
      else if (inc_cnt) cnt <= cnt + 1'b1;

      if (state == ST_LOAD) begin
        ioctl_addr <= {word_addr, cnt};
        ioctl_dout <= byte_sel(shreg, cnt, BIGEND);
      end

      if (slot_start) ioctl_index <= slot_id;

      if (slot_start || wr_ok) downloading <= 1'b1;
      else if (done_now)       downloading <= 1'b0;

      if (slot_start)     pending_done <= 1'b0;
      else if (slot_done) pending_done <= 1'b1;
      else if (done_now)  pending_done <= 1'b0;

      if (wr && !wr_ok)   overflow <= 1'b1;
      else if (slot_start) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Directed bench for jtframe_pocket_dwnld: big- and little-endian instances
// share one stimulus stream.
module tb_jtframe_pocket_dwnld;

  logic        clk = 1'b0;
  logic        rst, slot_start, slot_done, wr, prog_rdy;
  logic [7:0]  slot_id;
  logic [31:0] wr_addr, wr_data;

  logic [24:0] be_addr, le_addr;
  logic [7:0]  be_dout, le_dout, be_index, le_index;
  logic        be_wr, le_wr, be_dl, le_dl, be_ovf, le_ovf;
  logic [2:0]  be_lvl, le_lvl;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtframe_pocket_dwnld #(.AW(25), .FIFOAW(2), .BIGEND(1'b1)) dut_be (
    .clk(clk), .rst(rst), .slot_start(slot_start), .slot_id(slot_id),
    .slot_done(slot_done), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_rdy(prog_rdy), .ioctl_addr(be_addr), .ioctl_dout(be_dout),
    .ioctl_wr(be_wr), .ioctl_index(be_index), .downloading(be_dl),
    .overflow(be_ovf), .fifo_level(be_lvl)
  );

  jtframe_pocket_dwnld #(.AW(25), .FIFOAW(2), .BIGEND(1'b0)) dut_le (
    .clk(clk), .rst(rst), .slot_start(slot_start), .slot_id(slot_id),
    .slot_done(slot_done), .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .prog_rdy(prog_rdy), .ioctl_addr(le_addr), .ioctl_dout(le_dout),
    .ioctl_wr(le_wr), .ioctl_index(le_index), .downloading(le_dl),
    .overflow(le_ovf), .fifo_level(le_lvl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; single-cycle pulse inputs drop after being sampled.
  task automatic tick;
    @(posedge clk);
    #1;
    slot_start = 1'b0;
    slot_done  = 1'b0;
    wr         = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    wr      = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
  endtask

  task automatic wait_wr(input string tag, output int n);
    n = 0;
    while (be_wr !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_strobe"}, {31'd0, be_wr}, 32'd1);
  endtask

  task automatic exp_byte(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input int b, input int lat);
    int n;
    wait_wr(tag, n);
    if (lat >= 0) chk({tag, "_lat"}, n, lat);
    chk({tag, "_addr"}, {7'd0, be_addr}, a + b);
    chk({tag, "_dout_be"}, {24'd0, be_dout}, (d >> (24 - 8 * b)) & 32'hFF);
    chk({tag, "_dout_le"}, {24'd0, le_dout}, (d >> (8 * b)) & 32'hFF);
    chk({tag, "_wr_le"}, {31'd0, le_wr}, 32'd1);
  endtask

  task automatic ack;
    tick();
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n;

    rst = 1'b1; slot_start = 1'b0; slot_done = 1'b0; wr = 1'b0; prog_rdy = 1'b0;
    slot_id = 8'h00; wr_addr = 32'h0; wr_data = 32'h0;
    tick();
    tick();
    chk("rst_wr",    {31'd0, be_wr}, 32'd0);
    chk("rst_dl",    {31'd0, be_dl}, 32'd0);
    chk("rst_ovf",   {31'd0, be_ovf}, 32'd0);
    chk("rst_lvl",   {29'd0, be_lvl}, 32'd0);
    chk("rst_index", {24'd0, be_index}, 32'd0);
    chk("rst_addr",  {7'd0, be_addr}, 32'd0);
    chk("rst_dout",  {24'd0, le_dout}, 32'd0);
    rst = 1'b0;

    // Single word, both byte orders, slot_done arriving mid-word.
    slot_id = 8'h02; slot_start = 1'b1;
    tick();
    chk("t1_index", {24'd0, be_index}, 32'h02);
    chk("t1_dl_set", {31'd0, be_dl}, 32'd1);
    push_word(32'h100, 32'hA1B2C3D4);
    chk("t1_lvl", {29'd0, be_lvl}, 32'd1);
    exp_byte("t1b0", 32'h100, 32'hA1B2C3D4, 0, 2);
    slot_done = 1'b1;
    ack();
    exp_byte("t1b1", 32'h100, 32'hA1B2C3D4, 1, 1);
    chk("t1_index_hold", {24'd0, be_index}, 32'h02);
    chk("t1_dl_pending", {31'd0, be_dl}, 32'd1);
    ack();
    exp_byte("t1b2", 32'h100, 32'hA1B2C3D4, 2, 1);
    ack();
    exp_byte("t1b3", 32'h100, 32'hA1B2C3D4, 3, 1);
    chk("t1_dl_last", {31'd0, be_dl}, 32'd1);
    ack();
    tick();
    chk("t1_dl_fall", {31'd0, be_dl}, 32'd0);
    chk("t1_dl_fall_le", {31'd0, le_dl}, 32'd0);

    // Burst while the FSM is parked in WAIT: four fit, the fifth is dropped.
    slot_id = 8'h05; slot_start = 1'b1;
    tick();
    push_word(32'h1FC, 32'h55667788);
    exp_byte("t3pre0", 32'h1FC, 32'h55667788, 0, 2);
    chk("t3_ovf_clear", {31'd0, be_ovf}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      d = 32'h10203040 + i * 32'h01010101;
      push_word(32'h200 + 4 * i, d);
      chk("t3_lvl", {29'd0, be_lvl}, (i < 4) ? i + 1 : 4);
    end
    chk("t3_ovf_set", {31'd0, be_ovf}, 32'd1);
    chk("t3_ovf_set_le", {31'd0, le_ovf}, 32'd1);
    for (int b = 1; b < 4; b++) begin
      ack();
      exp_byte("t3pre", 32'h1FC, 32'h55667788, b, 1);
    end
    for (int w = 0; w < 4; w++) begin
      d = 32'h10203040 + w * 32'h01010101;
      for (int b = 0; b < 4; b++) begin
        ack();
        exp_byte("t3burst", 32'h200 + 4 * w, d, b, 1);
      end
    end
    ack();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (be_wr) n++;
    end
    chk("t3_no_extra", n, 0);
    chk("t3_lvl_empty", {29'd0, be_lvl}, 32'd0);
    chk("t3_ovf_sticky", {31'd0, be_ovf}, 32'd1);

    // New slot clears overflow; slot_done with two words in flight.
    slot_id = 8'h07; slot_start = 1'b1;
    tick();
    chk("t4_ovf_cleared", {31'd0, be_ovf}, 32'd0);
    chk("t4_index", {24'd0, be_index}, 32'h07);
    push_word(32'h500, 32'hCAFEF00D);
    push_word(32'h504, 32'h0BADBEEF);
    slot_done = 1'b1;
    tick();
    for (int w = 0; w < 2; w++) begin
      d = (w == 0) ? 32'hCAFEF00D : 32'h0BADBEEF;
      for (int b = 0; b < 4; b++) begin
        exp_byte("t4", 32'h500 + 4 * w, d, b, (w == 0 && b == 0) ? 0 : 1);
        chk("t4_dl_held", {31'd0, be_dl}, 32'd1);
        ack();
      end
    end
    tick();
    chk("t4_dl_fall", {31'd0, be_dl}, 32'd0);
    chk("t4_index_hold", {24'd0, be_index}, 32'h07);

    // prog_rdy outside WAIT must not create strobes or advance the byte.
    prog_rdy = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (be_wr) n++;
    end
    chk("t5_idle_nowr", n, 0);
    push_word(32'h600, 32'h11223344);
    exp_byte("t5b0", 32'h600, 32'h11223344, 0, 2);
    prog_rdy = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (be_wr) n++;
    end
    chk("t5_wait_hold", n, 0);
    prog_rdy = 1'b1;
    tick();
    prog_rdy = 1'b0;
    exp_byte("t5b1", 32'h600, 32'h11223344, 1, 1);
    for (int b = 2; b < 4; b++) begin
      ack();
      exp_byte("t5b", 32'h600, 32'h11223344, b, 1);
    end
    ack();

    // Reset after the second byte abandons the word and the queue.
    push_word(32'h700, 32'hDEADBEEF);
    push_word(32'h704, 32'h01234567);
    exp_byte("t6b0", 32'h700, 32'hDEADBEEF, 0, 1);
    ack();
    exp_byte("t6b1", 32'h700, 32'hDEADBEEF, 1, 1);
    rst = 1'b1;
    tick();
    chk("t6_rst_wr",  {31'd0, be_wr}, 32'd0);
    chk("t6_rst_dl",  {31'd0, be_dl}, 32'd0);
    chk("t6_rst_lvl", {29'd0, be_lvl}, 32'd0);
    chk("t6_rst_idx", {24'd0, be_index}, 32'd0);
    rst = 1'b0;
    prog_rdy = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (be_wr) n++;
    end
    prog_rdy = 1'b0;
    chk("t6_quiet", n, 0);
    push_word(32'h800, 32'h89ABCDEF);
    chk("t6_dl_restart", {31'd0, be_dl}, 32'd1);
    exp_byte("t6n0", 32'h800, 32'h89ABCDEF, 0, 2);
    ack();
    exp_byte("t6n1", 32'h800, 32'h89ABCDEF, 1, 1);
    ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtframe_pocket_dwnld.md
Name: jtframe_pocket_dwnld

Overview:
- Sequences APF bridge download traffic into the JTFRAME ioctl byte-write interface on the ROM clock.
- Accepts 32-bit bridge words that are already synchronised to clk, and buffers them in a small FIFO.
- Serialises each word into four ioctl byte writes, paced by the SDRAM loader's prog_rdy acknowledge.
- Owns the downloading flag, the ioctl_index latch and overflow reporting; sits between the bridge command block and the SDRAM download path.

Parameters:
- AW, 25: ioctl_addr width in bytes.
- FIFOAW, 2: log2 of FIFO depth in words (default depth 4).
- BIGEND, 1: 1 = byte 0 is wr_data[31:24] (APF order); 0 = byte 0 is wr_data[7:0].

Ports:
- clk, in, 1: ROM/download clock; the only clock.
- rst, in, 1: synchronous, active-high reset.
- slot_start, in, 1: one-cycle pulse; a data slot write request begins.
- slot_id, in, 8: slot index, sampled on slot_start.
- slot_done, in, 1: one-cycle pulse; the host reports all slots complete.
- wr, in, 1: one-cycle strobe per bridge word.
- wr_addr, in, 32: byte address of the word; bits [1:0] are ignored.
- wr_data, in, 32: word payload.
- prog_rdy, in, 1: loader acknowledge; the current byte has been written.
- ioctl_addr, out, AW: byte address.
- ioctl_dout, out, 8: byte data.
- ioctl_wr, out, 1: one-cycle write strobe.
- ioctl_index, out, 8: latched slot_id.
- downloading, out, 1: a download is in progress.
- overflow, out, 1: sticky flag; a word was dropped.
- fifo_level, out, FIFOAW+1: number of occupied FIFO entries.

Behaviour:
Reset:
- All outputs reset to 0.
- FIFO empties, the FSM goes to IDLE and the pending-done flag clears.
- Reset mid-word abandons the word; no further ioctl_wr is issued.

FIFO:
- Each entry is {wr_addr[AW-1:2], wr_data}.
- A write occurs on wr when not full.
- wr while full (level == 2^FIFOAW) with no pop in the same cycle: the word is dropped and overflow is set.
- wr and pop in the same cycle while full: the word is accepted and the level is unchanged.
- overflow clears only on rst or slot_start.

FSM states: IDLE, LOAD, EMIT, WAIT.
- IDLE: if the FIFO is not empty, pop the head into the shift register and word address, set byte count cnt=0, go to LOAD.
- LOAD: drive ioctl_addr = {word_addr, cnt} and ioctl_dout = the selected byte; go to EMIT.
- EMIT: ioctl_wr=1 for exactly this cycle; go to WAIT.
- WAIT:
  - prog_rdy is sampled only in this state; prog_rdy in any other state is ignored.
  - On prog_rdy with cnt<3: cnt+1, go to LOAD.
  - On prog_rdy with cnt==3 and FIFO not empty: pop the next entry, cnt=0, go to LOAD.
  - On prog_rdy with cnt==3 and FIFO empty: go to IDLE.
- ioctl_addr and ioctl_dout hold their values from LOAD until the next LOAD.

Latency and ordering:
- wr in cycle n into an empty FIFO with the FSM in IDLE → ioctl_wr high in cycle n+3.
- Minimum spacing between strobes: 3 cycles per byte when prog_rdy is returned the cycle after EMIT.
- Bytes within a word go in cnt order 0..3; words go in FIFO order. Addresses never wrap inside a word.

downloading:
- Set on slot_start or on an accepted wr.
- slot_done latches pending_done.
- downloading and pending_done clear in the first cycle where pending_done=1, FSM=IDLE and the FIFO is empty. The last byte is therefore always written before downloading falls.
- slot_done and wr in the same cycle: the word is accepted and done stays pending.
- slot_start while pending_done is set: pending_done clears and downloading stays 1.

ioctl_index:
- Updates only on slot_start; holds across slot_done.

Decomposition:
- Shared package jtframe_pocket_pkg holds:
  - the FSM state encoding (2-bit localparams ST_IDLE, ST_LOAD, ST_EMIT, ST_WAIT);
  - the byte-select function byte_sel(word, cnt, BIGEND);
  - the IDX_NVRAM/IDX_CHEAT index constants, for the consumers of ioctl_index.
- One sub-module: jtframe_pocket_dwnld_fifo, a synchronous FIFO with parameterised width and depth, full/empty/level outputs and push+pop-when-full support.

Test Plan:
- Single word: slot_start with id 8'h02; wr_addr=32'h100, wr_data=32'hA1B2C3D4, BIGEND=1; prog_rdy the cycle after each strobe → four ioctl_wr pulses at addr 0x100..0x103 with dout A1,B2,C3,D4. ioctl_index=02. downloading falls only after slot_done and the 4th prog_rdy.
- BIGEND=0, same word → dout D4,C3,B2,A1 at 0x100..0x103.
- Burst of 5 words in consecutive cycles with prog_rdy held off → words 0..3 accepted, the 5th dropped and overflow=1, fifo_level peaks at 4. Release prog_rdy → exactly 16 strobes in address order. The next slot_start clears overflow.
- slot_done pulsed while 2 words are queued → downloading stays 1 until the 8th prog_rdy, then drops to 0 in the following cycle.
- prog_rdy asserted during IDLE and LOAD → no extra strobe, cnt unchanged.
- rst asserted after the 2nd byte of a word → next cycle ioctl_wr=0, downloading=0, fifo_level=0. A following wr restarts cleanly at byte 0 of the new word.
